// File: rtl/led_fade_if.sv
// Control/status bundle between the LED fade sequencer and its host:
// mode button, enable, current mode, per-channel duty and PWM outputs.
interface led_fade_if #(
    parameter int unsigned CH = 4
) ();
    logic            mode_btn;
    logic            enable;
    logic [1:0]      mode;
    logic [CH*8-1:0] duty;
    logic [CH-1:0]   led;

    modport master (
        output mode_btn,
        output enable,
        input  mode,
        input  duty,
        input  led
    );

    modport slave (
        input  mode_btn,
        input  enable,
        output mode,
        output duty,
        output led
    );
endinterface

// File: rtl/led_fade_sequencer.sv
// Multi-channel LED sequencer: OFF / STATIC / BREATHE / CHASE patterns
// cycled by a button, with per-channel 8-bit duty driving free-running PWM.
module led_fade_sequencer #(
    parameter int unsigned CH          = 4,
    parameter int unsigned STEP_DIV    = 390625,
    parameter int unsigned CHASE_STEPS = 64,
    parameter int unsigned STATIC_LVL  = 128
) (
    input  logic       clk,
    input  logic       rst_n,
    led_fade_if.slave  bus
);

    localparam int unsigned PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int unsigned CW = (CHASE_STEPS > 1) ? $clog2(CHASE_STEPS) : 1;
    localparam int unsigned IW = (CH > 1) ? $clog2(CH) : 1;

    localparam logic [PW-1:0] PRE_LAST    = PW'(STEP_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST    = CW'(CHASE_STEPS - 1);
    localparam logic [IW-1:0] IDX_LAST    = IW'(CH - 1);
    localparam logic [7:0]    STATIC_DUTY = 8'(STATIC_LVL);

    typedef enum logic [1:0] {
        ST_OFF     = 2'd0,
        ST_STATIC  = 2'd1,
        ST_BREATHE = 2'd2,
        ST_CHASE   = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   pre_q, pre_d;
    logic [7:0]      ramp_q, ramp_d;
    logic            dir_dn_q, dir_dn_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      pwm_q, pwm_d;
    logic [CH*8-1:0] duty_q, duty_d;
    logic [CH-1:0]   led_q, led_d;
    logic            run_c;
    logic            tick_c;

    // State and datapath registers; reset clears everything without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_OFF;
            pre_q    <= '0;
            ramp_q   <= '0;
            dir_dn_q <= 1'b0;
            idx_q    <= '0;
            cnt_q    <= '0;
            pwm_q    <= '0;
            duty_q   <= '0;
            led_q    <= '0;
        end else begin
            state_q  <= state_d;
            pre_q    <= pre_d;
            ramp_q   <= ramp_d;
            dir_dn_q <= dir_dn_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            pwm_q    <= pwm_d;
            duty_q   <= duty_d;
            led_q    <= led_d;
        end
    end

    // Next-state: a button press beats a coincident tick and resets the pattern.
    always_comb begin
        state_d  = state_q;
        pre_d    = pre_q;
        ramp_d   = ramp_q;
        dir_dn_d = dir_dn_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        pwm_d    = pwm_q + 8'd1;
        duty_d   = '0;
        led_d    = '0;

        run_c  = bus.enable && ((state_q == ST_BREATHE) || (state_q == ST_CHASE));
        tick_c = run_c && (pre_q == PRE_LAST);

        if (bus.mode_btn) begin
            case (state_q)
                ST_OFF:     state_d = ST_STATIC;
                ST_STATIC:  state_d = ST_BREATHE;
                ST_BREATHE: state_d = ST_CHASE;
                default:    state_d = ST_OFF;
            endcase
            pre_d    = '0;
            ramp_d   = '0;
            dir_dn_d = 1'b0;
            idx_d    = '0;
            cnt_d    = '0;
        end else if (run_c) begin
            pre_d = tick_c ? '0 : pre_q + PW'(1);
            if (tick_c && (state_q == ST_BREATHE)) begin
                // Triangle turns around at the ends without dwelling: 510 ticks per period.
                if (!dir_dn_q) begin
                    if (ramp_q == 8'hFF) begin
                        ramp_d   = 8'hFE;
                        dir_dn_d = 1'b1;
                    end else begin
                        ramp_d = ramp_q + 8'd1;
                    end
                end else begin
                    if (ramp_q == 8'h00) begin
                        ramp_d   = 8'h01;
                        dir_dn_d = 1'b0;
                    end else begin
                        ramp_d = ramp_q - 8'd1;
                    end
                end
            end else if (tick_c) begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end

        // Duty follows the next-state values so it lands on the same edge as the change.
        for (int i = 0; i < int'(CH); i++) begin
            case (state_d)
                ST_STATIC:  duty_d[8*i +: 8] = STATIC_DUTY;
                ST_BREATHE: duty_d[8*i +: 8] = ramp_d;
                ST_CHASE:   duty_d[8*i +: 8] = (idx_d == IW'(i)) ? 8'hFF : 8'h00;
                default:    duty_d[8*i +: 8] = 8'h00;
            endcase
            led_d[i] = bus.enable && (pwm_q < duty_q[8*i +: 8]);
        end
    end

    assign bus.mode = state_q;
    assign bus.duty = duty_q;
    assign bus.led  = led_q;

endmodule

// File: tb/tb_led_fade_sequencer.sv
// Directed bench for led_fade_sequencer with STEP_DIV=4, CHASE_STEPS=2, CH=4.
module tb_led_fade_sequencer;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    led_fade_if #(.CH(4)) bus ();

    led_fade_sequencer #(
        .CH         (4),
        .STEP_DIV   (4),
        .CHASE_STEPS(2),
        .STATIC_LVL (128)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic pulse_btn();
        @(negedge clk);
        bus.mode_btn = 1'b1;
        @(negedge clk);
        bus.mode_btn = 1'b0;
    endtask

    // Count cycles with all four LEDs high over one full PWM period.
    task automatic count_on(output int n);
        n = 0;
        repeat (256) begin
            @(negedge clk);
            if (bus.led == 4'hF) n++;
        end
    endtask

    initial begin
        int n;
        int bad;
        logic [31:0] exp_duty;

        n_checks      = 0;
        n_pass        = 0;
        rst_n         = 1'b0;
        bus.mode_btn  = 1'b0;
        bus.enable    = 1'b0;

        #23;
        check("rst_mode", 32'(bus.mode), 32'd0);
        check("rst_duty", bus.duty, 32'h0);
        check("rst_led", 32'(bus.led), 32'h0);

        @(negedge clk);
        rst_n      = 1'b1;
        bus.enable = 1'b1;
        repeat (3) @(negedge clk);
        check("off_mode", 32'(bus.mode), 32'd0);
        check("off_duty", bus.duty, 32'h0);
        bad = 0;
        repeat (256) begin
            @(negedge clk);
            if (bus.led != 4'h0) bad++;
        end
        check("off_led_never_on", 32'(bad), 32'd0);

        // STATIC: duty 128 gives half-period on-time.
        pulse_btn();
        check("static_mode", 32'(bus.mode), 32'd1);
        check("static_duty", bus.duty, 32'h80808080);
        count_on(n);
        check("static_pwm_on", 32'(n), 32'd128);

        @(negedge clk);
        bus.enable = 1'b0;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.led != 4'h0) bad++;
        end
        check("disabled_led", 32'(bad), 32'd0);
        check("disabled_duty", bus.duty, 32'h80808080);
        bus.enable = 1'b1;
        count_on(n);
        check("reenable_pwm_on", 32'(n), 32'd128);

        // BREATHE: one tick per 4 clk, triangle 0..255..0.
        pulse_btn();
        check("breathe_mode", 32'(bus.mode), 32'd2);
        check("breathe_start", bus.duty, 32'h0);
        repeat (4 * 254) @(negedge clk);
        check("breathe_t254", bus.duty, 32'hFEFEFEFE);
        repeat (4) @(negedge clk);
        check("breathe_peak", bus.duty, 32'hFFFFFFFF);
        repeat (4) @(negedge clk);
        check("breathe_t256", bus.duty, 32'hFEFEFEFE);
        repeat (4 * 254) @(negedge clk);
        check("breathe_t510", bus.duty, 32'h0);
        repeat (4) @(negedge clk);
        check("breathe_t511", bus.duty, 32'h01010101);

        // Button on the tick cycle at ramp=10 must win over the step.
        repeat (36) @(negedge clk);
        check("breathe_r10", bus.duty, 32'h0A0A0A0A);
        repeat (3) @(negedge clk);
        check("breathe_r10_pre", bus.duty, 32'h0A0A0A0A);
        bus.mode_btn = 1'b1;
        @(negedge clk);
        bus.mode_btn = 1'b0;
        check("btn_tick_mode", 32'(bus.mode), 32'd3);

        // CHASE: 8 clk per channel, wrapping back to channel 0.
        for (int m = 0; m < 40; m++) begin
            exp_duty = 32'hFF << (8 * ((m / 8) % 4));
            check($sformatf("chase_%0d", m), bus.duty, exp_duty);
            @(negedge clk);
        end

        pulse_btn();
        check("wrap_off_mode", 32'(bus.mode), 32'd0);
        check("wrap_off_duty", bus.duty, 32'h0);
        pulse_btn();
        check("seq_static_mode", 32'(bus.mode), 32'd1);
        pulse_btn();
        check("reentry_mode", 32'(bus.mode), 32'd2);
        check("reentry_ramp_clear", bus.duty, 32'h0);
        repeat (4) @(negedge clk);
        check("reentry_first_tick", bus.duty, 32'h01010101);
        pulse_btn();
        check("chase2_mode", 32'(bus.mode), 32'd3);
        check("chase2_idx0", bus.duty, 32'h000000FF);

        // Asynchronous reset mid-chase, observed before the next rising edge.
        repeat (10) @(negedge clk);
        check("chase2_idx1", bus.duty, 32'h0000FF00);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_mode", 32'(bus.mode), 32'd0);
        check("async_rst_duty", bus.duty, 32'h0);
        check("async_rst_led", 32'(bus.led), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_mode", 32'(bus.mode), 32'd0);
        pulse_btn();
        check("post_rst_static", 32'(bus.mode), 32'd1);
        check("post_rst_duty", bus.duty, 32'h80808080);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/led_fade_sequencer.md
LED_FADE_SEQUENCER -- requirements
Module: led_fade_sequencer

Interface
REQ-001 Parameter CH, default 4, number of LED channels (2..8).
REQ-002 Parameter STEP_DIV, default 390625, clk cycles per brightness step tick (>=2).
REQ-003 Parameter CHASE_STEPS, default 64, step ticks per chase position (>=1).
REQ-004 Parameter STATIC_LVL, default 128, 8-bit duty used in STATIC mode.
REQ-005 clk  input  1  system clock, 100 MHz, all logic on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 mode_btn  input  1  single-cycle pulse, debounced and edge-detected upstream; advances mode.
REQ-008 enable  input  1  high = run; low = pause sequencing and blank LEDs.
REQ-009 mode  output  2  current state: 0 OFF, 1 STATIC, 2 BREATHE, 3 CHASE.
REQ-010 duty  output  CH*8  registered per-channel duty, channel i in bits [8i+7:8i].
REQ-011 led  output  CH  registered PWM outputs, one per channel.

Function
REQ-012 The block SHALL implement FSM OFF -> STATIC -> BREATHE -> CHASE -> OFF, advancing one state per mode_btn pulse.
REQ-013 A mode_btn pulse SHALL be honoured regardless of enable.
REQ-014 On any state change, prescaler, ramp, direction, chase index and chase counter SHALL be cleared (ramp=0, dir=up, index=0).
REQ-015 The prescaler SHALL count 0..STEP_DIV-1 while enable=1 and state is BREATHE or CHASE; tick SHALL assert for one cycle when count==STEP_DIV-1, then count wraps to 0.
REQ-016 The prescaler SHALL hold its value while enable=0.
REQ-017 If mode_btn and tick coincide, the state change SHALL win and the tick SHALL be discarded.
REQ-018 OFF: all duty = 0.
REQ-019 STATIC: all duty = STATIC_LVL.
REQ-020 BREATHE, 8-bit ramp, on tick: dir up and ramp<255 -> ramp+1; dir up and ramp==255 -> ramp=254, dir=down; dir down and ramp>0 -> ramp-1; dir down and ramp==0 -> ramp=1, dir=up.
REQ-021 BREATHE: full triangle period SHALL be 510 ticks; all duty = ramp.
REQ-022 CHASE: a counter 0..CHASE_STEPS-1 SHALL advance per tick; on wrap, index SHALL advance (CH-1 wraps to 0).
REQ-023 CHASE: duty[index] = 255, all other channels 0.
REQ-024 duty SHALL be registered, updating one clk after the causing tick or state change.
REQ-025 An 8-bit free-running pwm_cnt SHALL increment every clk, wrapping 255->0, independent of mode and enable.
REQ-026 led[i] SHALL be registered as (pwm_cnt < duty_i) when enable=1, and 0 when enable=0.
REQ-027 led[i] SHALL therefore be always 0 at duty 0 and high 255 of 256 cycles at duty 255.
REQ-028 mode output SHALL equal the FSM state register directly, with no extra latency.

Reset
REQ-029 While rst_n=0: state=OFF, mode=0, duty=0, led=0, pwm_cnt=0, prescaler=0, ramp=0, dir=up, index=0, chase counter=0.
REQ-030 Reset assertion SHALL take effect immediately, with no clock, from any state including mid-ramp.
REQ-031 After release, the first active clk edge SHALL start normal operation from OFF.

Verification (STEP_DIV=4, CHASE_STEPS=2, CH=4)
REQ-032 Release reset, send 4 mode_btn pulses -> mode reads 1,2,3,0 in turn; duty=0 in OFF; duty all 128 in STATIC.
REQ-033 BREATHE with enable=1 for 2040 clk -> ramp peaks at 255 after 255 ticks, next tick 254, reaches 0 at tick 510, then 1.
REQ-034 CHASE -> duty[0]=255 for 8 clk, then duty[1]=255, ... duty[3], then back to channel 0; other channels 0.
REQ-035 STATIC, toggle enable=0 for 100 clk -> led=0 throughout; duty unchanged; PWM resumes on re-enable.
REQ-036 Assert mode_btn on a tick cycle in BREATHE at ramp=10 -> mode=3, index=0, ramp cleared; no ramp step applied.
REQ-037 Assert rst_n=0 asynchronously mid-CHASE -> all outputs 0, mode=0 before the next clk edge.
